codec_mm_slave_v2: RTL
======================

Name: codec_mm_slave_v2

Overview:
Parametrised Avalon-MM slave that connects the host CPU to the WM8731 codec datapath: the I2C control packet path, the DAC FIFO and the ADC FIFO.
Compared with the first-generation slave it adds:
- configurable data, I2C-packet and FIFO-level widths;
- FIFO-level threshold interrupts with mask and write-1-to-clear pending bits;
- a read-back of the remaining burst count.
It sits between the Avalon interconnect and the codec I2C master / audio FIFOs.

Parameters:
DATA_W, 32, Avalon data width and FIFO word width (min 16)
I2C_W, 24, I2C packet width (<= DATA_W)
LVL_W, 8, FIFO fill-level width (<= 16)
BCNT_W, 8, burst count width

Ports:
Clk  in  1  clock
Rst_n  in  1  reset, asynchronous, active-high (name kept for codebase compatibility)
slave_chipselect  in  1  Avalon chip select
slave_read  in  1  read request
slave_write  in  1  write request
slave_address  in  3  word address
slave_writedata  in  DATA_W  write bus
slave_readdata  out  DATA_W  read bus
slave_waitrequest  out  1  stall
slave_beginbursttransfer  in  1  first beat of a burst
slave_burstcount  in  BCNT_W  beats in the burst
slave_irq  out  1  level interrupt
i2c_idle  in  1  I2C master idle
i2c_packet  out  I2C_W  I2C packet to send
wr_i2c  out  1  start-I2C pulse
dac_fifo_full  in  1  DAC FIFO full
dac_fifo_level  in  LVL_W  DAC FIFO fill level
dac_fifo_in  out  DATA_W  DAC FIFO write data
wr_dac_fifo  out  1  DAC FIFO push
adc_fifo_empty  in  1  ADC FIFO empty
adc_fifo_full  in  1  ADC FIFO full
adc_fifo_level  in  LVL_W  ADC FIFO fill level
adc_fifo_out  in  DATA_W  ADC FIFO head word
rd_adc_fifo  out  1  ADC FIFO pop

Behaviour:
- Definitions: valid_wr = chipselect & write; valid_rd = chipselect & read; a beat is accepted = valid & !waitrequest.
- Reset: all registers 0; all outputs 0; FSM in IDLE.
- Register map:
  - 0 I2C_CMD, RW: bits [I2C_W-1:0] drive i2c_packet.
  - 1 STATUS, RO, registered one cycle: bit 0 i2c_idle, bit 1 dac_full, bit 2 adc_full, bit 3 adc_empty, bit 4 adc_thr_hit, bit 5 dac_thr_low.
  - 2 DAC_DATA, RW: holds the last accepted write.
  - 3 ADC_DATA, RO: returns adc_fifo_out combinationally.
  - 4 IRQ_MASK, RW: bits [3:0].
  - 5 IRQ_PEND: bits [3:0]; writing 1 to a bit clears it.
  - 6 THRESH, RW: bits [LVL_W-1:0] hold ADC_THR; bits [16+LVL_W-1:16] hold DAC_THR.
  - 7 BURST_REM, RO: bCount.
- Read data: slave_readdata = 0 when !valid_rd. Unused bits read as 0.
- waitrequest (combinational) is asserted for any of:
  - a write to addr 0 while !i2c_idle;
  - a write to addr 2 while dac_fifo_full;
  - a read of addr 3 while adc_fifo_empty.
- wr_i2c: 1-cycle pulse, registered, asserted the cycle after an accepted write to addr 0. i2c_packet is already updated in that cycle.
- wr_dac_fifo: registered pulse, asserted the cycle after an accepted write to addr 2. dac_fifo_in = DAC_DATA.
- rd_adc_fifo: combinational; equals an accepted read of addr 3. Data is sampled on the same edge as the pop.
- Threshold flags: adc_thr_hit = (adc_fifo_level >= ADC_THR); dac_thr_low = (dac_fifo_level < DAC_THR). A threshold of 0 disables that flag.
- IRQ sources are rising edges, detected against a 1-cycle-delayed copy:
  - bit 0: i2c_idle 0->1 (transfer done);
  - bit 1: adc_thr_hit;
  - bit 2: dac_thr_low;
  - bit 3: adc_fifo_full (overrun warning).
- IRQ_PEND update: a bit sets on its event. If an event and a W1C of the same bit occur in the same cycle, the set wins.
- slave_irq: registered |(IRQ_PEND & IRQ_MASK); 1 cycle latency.
- Burst FSM with states IDLE, RBURST, WBURST:
  - IDLE: beginbursttransfer with burstcount != 0 loads bCount = burstcount. It goes to RBURST on read or WBURST on write. If read and write are both set, or burstcount = 0, the burst is ignored.
  - Each accepted beat in the current direction decrements bCount, including a beat accepted in the load cycle (load value becomes burstcount-1).
  - Exit to IDLE when a beat is accepted with bCount == 1, or in the load cycle when burstcount == 1.
  - All beats of a burst use the first beat's address.
  - Opposite-direction requests during a burst are decoded normally but do not count.
- Reset mid-burst or mid-stall: FSM returns to IDLE, bCount = 0, and no pulse is generated.

Optional Feature:
CODEC_BURST_EN
- Defined: burst FSM and BURST_REM are present as described above.
- Undefined: beginbursttransfer and burstcount are ignored, no FSM or counter is built, and addr 7 reads 0. Single-beat behaviour is identical.

Test Plan:
- Write 0x00341E to addr 0 while i2c_idle=1 -> waitrequest 0; wr_i2c high exactly 1 cycle later; i2c_packet=0x00341E.
- Write to addr 2 with dac_fifo_full=1 for 5 cycles, then 0 -> waitrequest high for 5 cycles; a single wr_dac_fifo pulse 1 cycle after accept; dac_fifo_in = written data.
- Set THRESH ADC_THR=16 and IRQ_MASK=0x2; ramp adc_fifo_level 15->16 -> PEND[1]=1 and slave_irq=1 one cycle later. A W1C of 0x2 in the same cycle as a fresh event leaves PEND[1]=1.
- Read burst of 4 beats from addr 3 with adc_fifo_empty toggling -> 4 rd_adc_fifo pulses, BURST_REM reads 3,2,1, FSM returns to IDLE after the 4th accept.
- Assert Rst_n mid-burst (bCount=2) -> bCount=0, IDLE, slave_irq=0, no wr_* pulse.
- burstcount=1 with beginbursttransfer -> one beat accepted, FSM stays IDLE.

Source files
------------

// File: rtl/codec_mm_slave_v2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : codec_mm_slave_v2                                            |
// | Description : Avalon-MM slave bridging the host CPU to the WM8731 codec    |
// |               datapath (I2C packet path, DAC FIFO, ADC FIFO), with FIFO    |
// |               threshold interrupts and optional burst support.             |
// |               Optional feature macro: CODEC_BURST_EN (burst FSM and        |
// |               BURST_REM read-back; when undefined addr 7 reads 0).         |
// | Revision    : 2.0 - parametrised widths, threshold IRQs, burst read-back   |
// +----------------------------------------------------------------------------+
module codec_mm_slave_v2 #(
   parameter int DATA_W = 32,
   parameter int I2C_W  = 24,
   parameter int LVL_W  = 8,
   parameter int BCNT_W = 8
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              slave_chipselect,
   input  logic              slave_read,
   input  logic              slave_write,
   input  logic [2:0]        slave_address,
   input  logic [DATA_W-1:0] slave_writedata,
   output logic [DATA_W-1:0] slave_readdata,
   output logic              slave_waitrequest,
   input  logic              slave_beginbursttransfer,
   input  logic [BCNT_W-1:0] slave_burstcount,
   output logic              slave_irq,
   input  logic              i2c_idle,
   output logic [I2C_W-1:0]  i2c_packet,
   output logic              wr_i2c,
   input  logic              dac_fifo_full,
   input  logic [LVL_W-1:0]  dac_fifo_level,
   output logic [DATA_W-1:0] dac_fifo_in,
   output logic              wr_dac_fifo,
   input  logic              adc_fifo_empty,
   input  logic              adc_fifo_full,
   input  logic [LVL_W-1:0]  adc_fifo_level,
   input  logic [DATA_W-1:0] adc_fifo_out,
   output logic              rd_adc_fifo
);

   localparam logic [2:0] c_ADDR_I2C_CMD  = 3'd0;
   localparam logic [2:0] c_ADDR_STATUS   = 3'd1;
   localparam logic [2:0] c_ADDR_DAC_DATA = 3'd2;
   localparam logic [2:0] c_ADDR_ADC_DATA = 3'd3;
   localparam logic [2:0] c_ADDR_IRQ_MASK = 3'd4;
   localparam logic [2:0] c_ADDR_IRQ_PEND = 3'd5;
   localparam logic [2:0] c_ADDR_THRESH   = 3'd6;

   logic              w_valid_wr, w_valid_rd, w_wait, w_wr_acc, w_rd_acc;
   logic [2:0]        w_wr_addr, w_rd_addr;
   logic              w_adc_thr_hit, w_dac_thr_low;
   logic [3:0]        w_evt_src, w_pend_clr;
   logic [DATA_W-1:0] w_rdata, w_burst_rem;

   logic [I2C_W-1:0]  r_i2c_cmd;
   logic [DATA_W-1:0] r_dac_data;
   logic [5:0]        r_status;
   logic [3:0]        r_irq_mask, r_irq_pend, r_prev_src;
   logic [LVL_W-1:0]  r_adc_thr, r_dac_thr;
   logic              r_wr_i2c, r_wr_dac, r_irq;

   assign w_valid_wr = slave_chipselect & slave_write;
   assign w_valid_rd = slave_chipselect & slave_read;

   // Stall only when the addressed resource cannot take the beat
   assign w_wait = (w_valid_wr && (w_wr_addr == c_ADDR_I2C_CMD)  && !i2c_idle)
                 | (w_valid_wr && (w_wr_addr == c_ADDR_DAC_DATA) && dac_fifo_full)
                 | (w_valid_rd && (w_rd_addr == c_ADDR_ADC_DATA) && adc_fifo_empty);

   assign w_wr_acc = w_valid_wr & ~w_wait;
   assign w_rd_acc = w_valid_rd & ~w_wait;

   assign slave_waitrequest = w_wait;
   assign rd_adc_fifo       = w_rd_acc && (w_rd_addr == c_ADDR_ADC_DATA);
   assign i2c_packet        = r_i2c_cmd;
   assign wr_i2c            = r_wr_i2c;
   assign dac_fifo_in       = r_dac_data;
   assign wr_dac_fifo       = r_wr_dac;
   assign slave_irq         = r_irq;

   // A zero threshold disables its flag
   assign w_adc_thr_hit = (r_adc_thr != '0) && (adc_fifo_level >= r_adc_thr);
   assign w_dac_thr_low = (r_dac_thr != '0) && (dac_fifo_level <  r_dac_thr);
   assign w_evt_src     = {adc_fifo_full, w_dac_thr_low, w_adc_thr_hit, i2c_idle};
   assign w_pend_clr    = (w_wr_acc && (w_wr_addr == c_ADDR_IRQ_PEND)) ? slave_writedata[3:0] : 4'b0;

`ifdef CODEC_BURST_EN
   localparam logic [1:0]        c_ST_IDLE   = 2'd0;
   localparam logic [1:0]        c_ST_RBURST = 2'd1;
   localparam logic [1:0]        c_ST_WBURST = 2'd2;
   localparam logic [BCNT_W-1:0] c_BCNT_ONE  = {{(BCNT_W-1){1'b0}}, 1'b1};

   logic [1:0]        r_state;
   logic [BCNT_W-1:0] r_bcount;
   logic [2:0]        r_burst_addr;
   logic              w_burst_start, w_start_acc;

   // Beats of a burst reuse the first beat's address; the other direction decodes normally
   assign w_rd_addr     = (r_state == c_ST_RBURST) ? r_burst_addr : slave_address;
   assign w_wr_addr     = (r_state == c_ST_WBURST) ? r_burst_addr : slave_address;
   assign w_burst_start = slave_chipselect && slave_beginbursttransfer
                       && (slave_burstcount != '0) && (slave_read ^ slave_write);
   assign w_start_acc   = slave_read ? w_rd_acc : w_wr_acc;

   // Remaining-beat count, zero-extended for read-back
   always_comb begin
      w_burst_rem = '0;
      w_burst_rem[BCNT_W-1:0] = r_bcount;
   end

   // Burst tracker: load on the first beat, count accepted beats in the burst direction
   always_ff @(posedge Clk or posedge Rst_n) begin
      if (Rst_n) begin
         r_state      <= c_ST_IDLE;
         r_bcount     <= '0;
         r_burst_addr <= '0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (w_burst_start) begin
                  r_burst_addr <= slave_address;
                  if (w_start_acc && (slave_burstcount == c_BCNT_ONE)) begin
                     r_bcount <= '0;
                  end else begin
                     r_bcount <= w_start_acc ? (slave_burstcount - c_BCNT_ONE) : slave_burstcount;
                     r_state  <= slave_read ? c_ST_RBURST : c_ST_WBURST;
                  end
               end
            end
            c_ST_RBURST, c_ST_WBURST: begin
               if ((r_state == c_ST_RBURST) ? w_rd_acc : w_wr_acc) begin
                  if (r_bcount == c_BCNT_ONE) begin
                     r_bcount <= '0;
                     r_state  <= c_ST_IDLE;
                  end else begin
                     r_bcount <= r_bcount - c_BCNT_ONE;
                  end
               end
            end
            default: begin
               r_state  <= c_ST_IDLE;
               r_bcount <= '0;
            end
         endcase
      end
   end
`else
   logic w_unused_burst;

   assign w_rd_addr      = slave_address;
   assign w_wr_addr      = slave_address;
   assign w_burst_rem    = '0;
   assign w_unused_burst = ^{slave_beginbursttransfer, slave_burstcount};
`endif

   // Read-data mux; the bus reads 0 outside a valid read
   always_comb begin
      w_rdata = '0;
      case (w_rd_addr)
         c_ADDR_I2C_CMD:  w_rdata[I2C_W-1:0] = r_i2c_cmd;
         c_ADDR_STATUS:   w_rdata[5:0]       = r_status;
         c_ADDR_DAC_DATA: w_rdata            = r_dac_data;
         c_ADDR_ADC_DATA: w_rdata            = adc_fifo_out;
         c_ADDR_IRQ_MASK: w_rdata[3:0]       = r_irq_mask;
         c_ADDR_IRQ_PEND: w_rdata[3:0]       = r_irq_pend;
         c_ADDR_THRESH: begin
            w_rdata[LVL_W-1:0] = r_adc_thr;
            for (int i = 0; i < LVL_W; i++)
               if (16 + i < DATA_W) w_rdata[16 + i] = r_dac_thr[i];
         end
         default:         w_rdata            = w_burst_rem;
      endcase
      slave_readdata = w_valid_rd ? w_rdata : '0;
   end

   // Host-writable registers and the one-cycle I2C / DAC push strobes
   always_ff @(posedge Clk or posedge Rst_n) begin
      if (Rst_n) begin
         r_i2c_cmd  <= '0;
         r_dac_data <= '0;
         r_irq_mask <= '0;
         r_adc_thr  <= '0;
         r_dac_thr  <= '0;
         r_wr_i2c   <= 1'b0;
         r_wr_dac   <= 1'b0;
      end else begin
         r_wr_i2c <= w_wr_acc && (w_wr_addr == c_ADDR_I2C_CMD);
         r_wr_dac <= w_wr_acc && (w_wr_addr == c_ADDR_DAC_DATA);
         if (w_wr_acc) begin
            case (w_wr_addr)
               c_ADDR_I2C_CMD:  r_i2c_cmd  <= slave_writedata[I2C_W-1:0];
               c_ADDR_DAC_DATA: r_dac_data <= slave_writedata;
               c_ADDR_IRQ_MASK: r_irq_mask <= slave_writedata[3:0];
               c_ADDR_THRESH: begin
                  r_adc_thr <= slave_writedata[LVL_W-1:0];
                  for (int i = 0; i < LVL_W; i++)
                     if (16 + i < DATA_W) r_dac_thr[i] <= slave_writedata[16 + i];
               end
               default: ;
            endcase
         end
      end
   end

   // Status snapshot, edge detection, pending bits (set beats clear) and IRQ line
   always_ff @(posedge Clk or posedge Rst_n) begin
      if (Rst_n) begin
         r_status   <= '0;
         r_prev_src <= '0;
         r_irq_pend <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_status   <= {w_dac_thr_low, w_adc_thr_hit, adc_fifo_empty, adc_fifo_full, dac_fifo_full, i2c_idle};
         r_prev_src <= w_evt_src;
         r_irq_pend <= (r_irq_pend & ~w_pend_clr) | (w_evt_src & ~r_prev_src);
         r_irq      <= |(r_irq_pend & r_irq_mask);
      end
   end

endmodule
`default_nettype wire
